// File: rtl/fp_norm_ctrl.sv
// rtl/fp_norm_ctrl.sv - multi-cycle post-add mantissa normalization sequencer
module fp_norm_ctrl #(
    parameter int MANT_BITS = 24,
    parameter int EXP_BITS  = 8,
    parameter int CHUNK     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MANT_BITS:0]   mant_in,
    input  logic [EXP_BITS-1:0]  exp_in,
    output logic                 busy,
    output logic                 done,
    output logic [MANT_BITS-1:0] mant_out,
    output logic [EXP_BITS-1:0]  exp_out,
    output logic                 zero_flag,
    output logic                 underflow_flag,
    output logic                 overflow_flag
);

    localparam int AMT_W = $clog2(CHUNK) + 1;
    localparam logic [EXP_BITS-1:0] EXP_MAX   = '1;
    localparam logic [EXP_BITS-1:0] CHUNK_EXP = EXP_BITS'(CHUNK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSHIFT = 2'd1,
        SCAN   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [MANT_BITS:0]   mant_reg, mant_reg_nxt;
    logic [EXP_BITS-1:0]  exp_reg, exp_reg_nxt;
    logic [MANT_BITS-1:0] mant_out_nxt;
    logic [EXP_BITS-1:0]  exp_out_nxt;
    logic                 zero_nxt, underflow_nxt, overflow_nxt;

    // Datapath helpers shared by the scan and carry paths
    logic [CHUNK-1:0]     grp;
    logic [AMT_W-1:0]     amt;
    logic [EXP_BITS-1:0]  amt_ext;
    logic [EXP_BITS:0]    exp_inc;
    logic [EXP_BITS-1:0]  clamp_sh;
    logic [MANT_BITS-1:0] mant_low;

    assign grp      = mant_reg[MANT_BITS-1 -: CHUNK];
    assign amt_ext  = EXP_BITS'(amt);
    assign exp_inc  = {1'b0, exp_reg} + {{EXP_BITS{1'b0}}, 1'b1};
    assign clamp_sh = (exp_reg == '0) ? '0 : exp_reg - 1'b1;
    assign mant_low = mant_reg[MANT_BITS-1:0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Narrow leading-zero count of the current top group; CHUNK when all zero
    always_comb begin
        amt = AMT_W'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (grp[i]) begin
                amt = AMT_W'(CHUNK - 1 - i);
            end
        end
    end

    // Next-state and next-value decode for the sequencer
    always_comb begin
        state_nxt     = state;
        mant_reg_nxt  = mant_reg;
        exp_reg_nxt   = exp_reg;
        mant_out_nxt  = mant_out;
        exp_out_nxt   = exp_out;
        zero_nxt      = zero_flag;
        underflow_nxt = underflow_flag;
        overflow_nxt  = overflow_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    mant_reg_nxt  = mant_in;
                    exp_reg_nxt   = exp_in;
                    zero_nxt      = 1'b0;
                    underflow_nxt = 1'b0;
                    overflow_nxt  = 1'b0;
                    if (mant_in[MANT_BITS]) begin
                        state_nxt = RSHIFT;
                    end else if (mant_in == '0) begin
                        state_nxt    = DONE;
                        mant_out_nxt = '0;
                        exp_out_nxt  = '0;
                        zero_nxt     = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end
            RSHIFT: begin
                state_nxt = DONE;
                // Saturate instead of letting the incremented exponent wrap
                if (exp_inc >= {1'b0, EXP_MAX}) begin
                    overflow_nxt = 1'b1;
                    mant_out_nxt = '0;
                    exp_out_nxt  = EXP_MAX;
                end else begin
                    mant_out_nxt = mant_reg[MANT_BITS:1];
                    exp_out_nxt  = exp_inc[EXP_BITS-1:0];
                end
            end
            SCAN: begin
                if (amt_ext < exp_reg) begin
                    if (grp != '0) begin
                        state_nxt    = DONE;
                        mant_reg_nxt = {1'b0, mant_low << amt};
                        exp_reg_nxt  = exp_reg - amt_ext;
                        mant_out_nxt = mant_low << amt;
                        exp_out_nxt  = exp_reg - amt_ext;
                    end else begin
                        mant_reg_nxt = {1'b0, mant_low << CHUNK};
                        exp_reg_nxt  = exp_reg - CHUNK_EXP;
                    end
                end else begin
                    // Exponent would drop to zero or below: emit a denormal
                    state_nxt     = DONE;
                    mant_reg_nxt  = {1'b0, mant_low << clamp_sh};
                    exp_reg_nxt   = '0;
                    mant_out_nxt  = mant_low << clamp_sh;
                    exp_out_nxt   = '0;
                    underflow_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mant_reg       <= '0;
            exp_reg        <= '0;
            mant_out       <= '0;
            exp_out        <= '0;
            zero_flag      <= 1'b0;
            underflow_flag <= 1'b0;
            overflow_flag  <= 1'b0;
        end else begin
            mant_reg       <= mant_reg_nxt;
            exp_reg        <= exp_reg_nxt;
            mant_out       <= mant_out_nxt;
            exp_out        <= exp_out_nxt;
            zero_flag      <= zero_nxt;
            underflow_flag <= underflow_nxt;
            overflow_flag  <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// tb/tb_fp_norm_ctrl.sv - directed self-checking bench for fp_norm_ctrl
module tb_fp_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] mant_in;
    logic [7:0]  exp_in;
    logic        busy;
    logic        done;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic        zero_flag;
    logic        underflow_flag;
    logic        overflow_flag;

    int ncmp = 0;
    int nerr = 0;

    fp_norm_ctrl #(.MANT_BITS(24), .EXP_BITS(8), .CHUNK(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mant_in        (mant_in),
        .exp_in         (exp_in),
        .busy           (busy),
        .done           (done),
        .mant_out       (mant_out),
        .exp_out        (exp_out),
        .zero_flag      (zero_flag),
        .underflow_flag (underflow_flag),
        .overflow_flag  (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation; latency counts negedge samples after the accepting edge.
    // With poke set, extra starts are driven mid-operation and during DONE.
    task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e,
                          input int lat_exp, input logic [23:0] m_exp, input logic [7:0] e_exp,
                          input logic z_exp, input logic u_exp, input logic o_exp, input bit poke);
        int  lat;
        bit  got;
        bit  busy_ok;
        @(negedge clk);
        mant_in = m;
        exp_in  = e;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        got = 0;
        busy_ok = 1;
        for (int cnt = 1; cnt <= 40; cnt++) begin
            @(negedge clk);
            if (poke) begin
                start   = (cnt == 2);
                mant_in = 25'h1555555;
                exp_in  = 8'd7;
            end
            if (!busy) busy_ok = 0;
            if (done) begin
                lat = cnt;
                got = 1;
                break;
            end
        end
        check_val({tag, " done_seen"}, 32'(got), 32'd1);
        check_val({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check_val({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        check_val({tag, " mant_out"}, 32'(mant_out), 32'(m_exp));
        check_val({tag, " exp_out"}, 32'(exp_out), 32'(e_exp));
        check_val({tag, " flags"}, {29'd0, zero_flag, underflow_flag, overflow_flag},
                  {29'd0, z_exp, u_exp, o_exp});
        if (poke) begin
            start   = 1'b1;
            mant_in = 25'h0000001;
            exp_in  = 8'd50;
        end
        @(negedge clk);
        start = 1'b0;
        check_val({tag, " done_pulse"}, 32'(done), 32'd0);
        check_val({tag, " idle_after"}, 32'(busy), 32'd0);
        if (poke) begin
            check_val({tag, " hold_mant"}, 32'(mant_out), 32'(m_exp));
            check_val({tag, " hold_exp"}, 32'(exp_out), 32'(e_exp));
        end
    endtask

    initial begin
        bit saw_done;
        rst     = 1'b1;
        start   = 1'b0;
        mant_in = '0;
        exp_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset mant", 32'(mant_out), 32'd0);
        check_val("reset exp", 32'(exp_out), 32'd0);
        check_val("reset flags", {29'd0, zero_flag, underflow_flag, overflow_flag}, 32'd0);
        rst = 1'b0;

        //        tag          mant_in        exp  lat mant_out     exp  z  u  o  poke
        run_op("normalized", 25'h0800000, 8'd100, 2, 24'h800000, 8'd100, 0, 0, 0, 0);
        run_op("carry",      25'h1000001, 8'd100, 2, 24'h800000, 8'd101, 0, 0, 0, 0);
        run_op("carry_ovf",  25'h1000001, 8'd254, 2, 24'h000000, 8'd255, 0, 0, 1, 0);
        run_op("deep_scan",  25'h0000010, 8'd100, 6, 24'h800000, 8'd81,  0, 0, 0, 1);
        run_op("two_groups", 25'h0030000, 8'd20,  3, 24'hC00000, 8'd14,  0, 0, 0, 0);
        run_op("underflow",  25'h0000100, 8'd10,  4, 24'h020000, 8'd0,   0, 1, 0, 0);
        run_op("exp_zero",   25'h0000100, 8'd0,   2, 24'h000100, 8'd0,   0, 1, 0, 0);
        run_op("zero",       25'h0000000, 8'd55,  1, 24'h000000, 8'd0,   1, 0, 0, 1);
        run_op("pre_reset",  25'h0C00000, 8'd5,   2, 24'hC00000, 8'd5,   0, 0, 0, 0);

        // Abort a deep scan with reset sampled at edge k+3
        @(negedge clk);
        mant_in = 25'h0000010;
        exp_in  = 8'd100;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort done", 32'(done), 32'd0);
        check_val("abort mant", 32'(mant_out), 32'd0);
        check_val("abort exp", 32'(exp_out), 32'd0);
        check_val("abort flags", {29'd0, zero_flag, underflow_flag, overflow_flag}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check_val("abort quiet", 32'(saw_done), 32'd0);

        run_op("post_reset", 25'h1FFFFFF, 8'd1, 2, 24'hFFFFFF, 8'd2, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fp_norm_ctrl.md
Name: fp_norm_ctrl

Overview:
- Multi-cycle post-add normalization sequencer for the floating-point co-processor.
- Takes a raw adder mantissa (with carry bit) and exponent, and scans for the leading one one CHUNK-bit group per cycle, reusing a narrow leading-one detector instead of a full-width LZC.
- Shifts the mantissa and adjusts the exponent, then delivers the normalized result with flags via a start/busy/done handshake.
- Sits between the mantissa adder and the rounding/pack stage.

Parameters:
- MANT_BITS, 24, mantissa width including hidden bit; the leading one lands at bit MANT_BITS-1.
- EXP_BITS, 8, biased exponent width.
- CHUNK, 4, bits examined per SCAN cycle; power of 2, at most MANT_BITS.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mant_in  input  MANT_BITS+1  raw mantissa; MSB is adder carry-out
- exp_in  input  EXP_BITS  biased exponent of mant_in
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse; result valid
- mant_out  output  MANT_BITS  normalized mantissa
- exp_out  output  EXP_BITS  adjusted exponent
- zero_flag  output  1  mant_in was zero
- underflow_flag  output  1  result is denormal (exp_out=0)
- overflow_flag  output  1  carry pushed exponent to all-ones

Behaviour:
- Reset: when rst=1 at an edge, state goes to IDLE and every output and internal register clears to 0. This applies from any state; an operation in progress is aborted and no done is emitted.
- States: IDLE, RSHIFT, SCAN, DONE.
- Outputs are registered. mant_out, exp_out and the flags update only on entry to DONE and hold until the next accepted start.
- All three flags clear when a start is accepted.
- IDLE, start=1 (accepting edge k): load mant_reg <= mant_in and exp_reg <= exp_in, then branch:
  - mant_in[MANT_BITS]=1 -> RSHIFT.
  - mant_in==0 -> DONE with mant_out=0, exp_out=0, zero_flag=1.
  - Otherwise -> SCAN.
- start is ignored in every non-IDLE state, including DONE.
- RSHIFT (one cycle):
  - mant_out = mant_reg[MANT_BITS:1]; the LSB is truncated.
  - exp_out = exp_reg+1.
  - If exp_reg+1 equals 2^EXP_BITS-1: overflow_flag=1, mant_out=0, exp_out=all-ones.
  - Next state is DONE.
- SCAN, one group per cycle:
  - g = mant_reg[MANT_BITS-1 -: CHUNK]; amt = CHUNK if g==0, else the leading-zero count of g (0..CHUNK-1).
  - If amt < exp_reg and g!=0: shift left by amt, exp_reg -= amt, go to DONE and present the result.
  - If amt < exp_reg and g==0: shift left by CHUNK, exp_reg -= CHUNK, stay in SCAN.
  - If amt >= exp_reg (clamp): shift left by exp_reg-1 (0 if exp_reg==0), exp_out=0, underflow_flag=1, go to DONE.
  - Zero-filled left shifts only. Exponent arithmetic never wraps.
  - SCAN always terminates because mant_reg is nonzero; there are at most ceil(MANT_BITS/CHUNK) SCAN cycles.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A new start can be accepted on the edge after DONE is left.
- Latency, counted from accepting edge k to the edge that raises done:
  - zero input: k+1
  - carry input: k+2
  - scan input: k+2+Z, where Z is the number of all-zero groups skipped.
- Throughput: one operation in flight; no queuing.

Test Plan (MANT_BITS=24, EXP_BITS=8, CHUNK=4):
- Already normalized: mant_in=25'h0800000, exp_in=100 -> done at k+2, mant_out=24'h800000, exp_out=100, all flags 0.
- Carry: mant_in=25'h1000001, exp_in=100 -> done at k+2, mant_out=24'h800000, exp_out=101. Then exp_in=254 with carry -> overflow_flag=1, exp_out=255, mant_out=0.
- Deep scan: mant_in=25'h0000010, exp_in=100 -> Z=4, done at k+6, mant_out=24'h800000, exp_out=81, busy high from k+1 through the done cycle.
- Underflow clamp: mant_in=25'h0000100, exp_in=10 -> done at k+4, mant_out=24'h020000, exp_out=0, underflow_flag=1.
- Zero and ignored start: mant_in=0, exp_in=55 -> done at k+1, zero_flag=1, mant_out=0, exp_out=0. Also pulse start with new data while busy or in DONE -> ignored; outputs keep the current result.
- Reset mid-op: start the deep-scan case, assert rst at k+3 -> next cycle busy=0, done=0, all outputs 0, and no done follows. A start after rst deasserts completes normally.
